// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
//   uart_tx_state_t : transmitter FSM state encoding
//   uart_div        : rounded clocks-per-bit divider
//   uart_parity     : parity of a data word (even, or odd when odd=1)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Clocks per line bit, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

    // Upper bits of narrower words are zero and do not affect the XOR.
    function automatic logic uart_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers carrying one extra bit.
// Ports: clk, reset_n (sync, active-low), push/wr_data, pop/rd_data
// (show-ahead head word), full, empty, count (words held).
// Push is ignored when full, pop is ignored when empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready stream in, FIFO, serial frames out.
// Frames: start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
// Optional feature: define UART_TX_PARITY_EN to add the parity bit
// (even, or odd when PARITY_ODD=1).
// Ports: clk, reset_n (sync, active-low), data_in/data_valid/data_ready
// (stream input), tx (registered serial line, idle high), busy (frame in
// flight or words queued), fifo_count (words held in the FIFO).
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DATA_BITS-1:0]            data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned DIV = uart_div(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = 4;

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(PARITY);
`endif
    localparam logic [2:0] S_STOP   = 3'(STOP);

    // Elaboration-time parameter checks.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_stream: CLOCK_FREQ/BAUD_RATE gives DIV < 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_stream: illegal DATA_BITS/STOP_BITS/PARITY_ODD/FIFO_DEPTH");
    end

    logic [2:0]           state, state_n;
    logic [CW-1:0]        div_cnt, div_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 tx_n;
    logic                 bit_end;
    logic                 pop;
    logic                 push;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit, par_n;
`endif

    assign push = data_valid && !fifo_full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (data_in),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign data_ready = !fifo_full;
    assign busy       = (state != S_IDLE) || !fifo_empty;
    assign bit_end    = (div_cnt == CW'(DIV - 1));

    // Next-state, divider, bit counter, shifter and next line value.
    always_comb begin
        state_n = state;
        div_n   = (state == S_IDLE || bit_end) ? '0 : div_cnt + CW'(1);
        bit_n   = bit_cnt;
        shreg_n = shreg;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        bit_n = '0;
                        // Chain straight into the next frame when words are queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (pop) shreg_n = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
        par_n = pop ? uart_parity(9'(fifo_rd_data), PARITY_ODD != 0) : par_bit;
`endif

        // tx is registered from the next state so the start bit shows right after the pop edge.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) par_bit <= 1'b0;
        else          par_bit <= par_n;
    end
`endif

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed testbench for uart_tx_stream with DIV=8 (CLOCK_FREQ=800, BAUD_RATE=100).
// dut1: 8 data bits, 1 stop, depth 16. dut2: 7 data bits, 2 stops, depth 4.
// dut3 (parity builds only): odd parity.
module tb_uart_tx_stream;

    localparam int unsigned DIV = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned NB1 = 10 + PB;
    localparam int unsigned FR1 = DIV * NB1;
    localparam int unsigned NB2 = 10 + PB;
    localparam int unsigned FR2 = DIV * NB2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, tx, busy;
    logic [4:0] fifo_count;
    logic [6:0] data_in2;
    logic       data_valid2;
    logic       data_ready2, tx2, busy2;
    logic [2:0] fifo_count2;
`ifdef UART_TX_PARITY_EN
    logic       data_valid3;
    logic       data_ready3, tx3, busy3;
    logic [1:0] fifo_count3;
`endif

    int passed = 0;
    int total  = 0;
    logic cap_tx   [0:1799];
    logic cap_busy [0:1799];

    always #5 clk = ~clk;

    uart_tx_stream #(
        .CLOCK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1),
        .FIFO_DEPTH(16), .PARITY_ODD(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_stream #(
        .CLOCK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2),
        .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in2), .data_valid(data_valid2),
        .data_ready(data_ready2), .tx(tx2), .busy(busy2), .fifo_count(fifo_count2)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_stream #(
        .CLOCK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1),
        .FIFO_DEPTH(2), .PARITY_ODD(1)
    ) dut3 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid3),
        .data_ready(data_ready3), .tx(tx3), .busy(busy3), .fifo_count(fifo_count3)
    );
`endif

    // Record dut1 line and busy on n successive negedges, starting now.
    task automatic capture1(input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = tx;
            cap_busy[i] = busy;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; data_valid = 1'b0; data_in = '0;
        data_valid2 = 1'b0; data_in2 = '0;
`ifdef UART_TX_PARITY_EN
        data_valid3 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else passed++;
        total++; if (data_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", data_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
        total++; if (tx2 !== 1'b1 || data_ready2 !== 1'b1 || fifo_count2 !== 3'd0)
            $display("FAIL reset_dut2: got tx=%b rdy=%b cnt=%0d expected 1 1 0", tx2, data_ready2, fifo_count2);
        else passed++;
`ifdef UART_TX_PARITY_EN
        total++; if (data_ready3 !== 1'b1 || fifo_count3 !== 2'd0)
            $display("FAIL reset_dut3: got rdy=%b cnt=%0d expected 1 0", data_ready3, fifo_count3);
        else passed++;
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [10:0] exp;
        int bad;
`ifdef UART_TX_PARITY_EN
        exp = 11'b10010101010;
`else
        exp = {1'b0, 10'b1010101010};
`endif
        data_in = 8'h55; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        total++; if (fifo_count !== 5'd1) $display("FAIL single_count_e0: got %0d expected 1", fifo_count); else passed++;
        total++; if (tx !== 1'b1) $display("FAIL single_tx_e0: got %b expected 1", tx); else passed++;
        @(negedge clk);
        total++; if (fifo_count !== 5'd0) $display("FAIL single_count_e1: got %0d expected 0", fifo_count); else passed++;
        total++; if (tx !== 1'b0) $display("FAIL single_start: got %b expected 0", tx); else passed++;
        capture1(FR1 + 2);
        for (int b = 0; b < int'(NB1); b++) begin
            bad = 0;
            for (int j = 0; j < 8; j++) if (cap_tx[b*8 + j] !== exp[b]) bad++;
            total++;
            if (bad != 0) $display("FAIL single_bit%0d: %0d of 8 samples differ from expected %b", b, bad, exp[b]);
            else passed++;
        end
        total++; if (cap_busy[FR1-1] !== 1'b1) $display("FAIL single_busy_last: got %b expected 1", cap_busy[FR1-1]); else passed++;
        total++; if (cap_busy[FR1] !== 1'b0 || cap_tx[FR1] !== 1'b1)
            $display("FAIL single_end: got busy=%b tx=%b expected 0 1", cap_busy[FR1], cap_tx[FR1]);
        else passed++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [10:0] exp;
        logic        odd_cap [0:95];
        int          bad;
        exp = 11'b11000001110;
        data_in = 8'h07; data_valid = 1'b1; data_valid3 = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; data_valid3 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < int'(FR1) + 1; i++) begin
            cap_tx[i] = tx; cap_busy[i] = busy; odd_cap[i] = tx3;
            @(negedge clk);
        end
        for (int b = 0; b < 11; b++) begin
            bad = 0;
            for (int j = 0; j < 8; j++) if (cap_tx[b*8 + j] !== exp[b]) bad++;
            total++;
            if (bad != 0) $display("FAIL parity_even_bit%0d: %0d of 8 samples differ from expected %b", b, bad, exp[b]);
            else passed++;
        end
        total++; if (odd_cap[9*8 + 4] !== 1'b0) $display("FAIL parity_odd_bit: got %b expected 0", odd_cap[9*8 + 4]); else passed++;
        total++; if (cap_busy[87] !== 1'b1 || cap_busy[88] !== 1'b0)
            $display("FAIL parity_len88: got busy87=%b busy88=%b expected 1 0", cap_busy[87], cap_busy[88]);
        else passed++;
        total++; if (busy3 !== 1'b0) $display("FAIL parity_odd_done: got busy=%b expected 0", busy3); else passed++;
    endtask
`endif

    task automatic test_burst;
        int idx, cyc, peak, ready_bad, s, bad, b;
        logic will;
        logic [7:0] w;
        logic expb;
        idx = 0; cyc = 0; peak = 0; ready_bad = 0;
        data_in = 8'hA0; data_valid = 1'b1;
        fork
            capture1(1800);
            begin
                while (idx < 20 && cyc < 2000) begin
                    will = data_ready;
                    if ((fifo_count == 5'd16) == data_ready) ready_bad++;
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                    @(negedge clk);
                    cyc++;
                    if (will) idx++;
                    data_in = 8'hA0 + 8'(idx);
                end
                data_valid = 1'b0;
            end
        join
        total++; if (idx != 20) $display("FAIL burst_accepted: got %0d expected 20", idx); else passed++;
        total++; if (peak != 16) $display("FAIL burst_peak_count: got %0d expected 16", peak); else passed++;
        total++; if (ready_bad != 0) $display("FAIL burst_ready_vs_count: %0d cycles wrong, expected 0", ready_bad); else passed++;
        s = -1;
        for (int i = 0; i < 100; i++) if (s < 0 && cap_tx[i] === 1'b0) s = i;
        total++; if (s != 2) $display("FAIL burst_first_start: got %0d expected 2", s); else passed++;
        if (s < 0) s = 2;
        for (int f = 0; f < 20; f++) begin
            w = 8'hA0 + 8'(f);
            bad = 0;
            for (int i = 0; i < int'(FR1); i++) begin
                b = i / 8;
                if (b == 0)                    expb = 1'b0;
                else if (b <= 8)               expb = w[b-1];
                else if (PB == 1 && b == 9)    expb = ^w;
                else                           expb = 1'b1;
                if (cap_tx[s + f*int'(FR1) + i] !== expb) bad++;
            end
            total++;
            if (bad != 0) $display("FAIL burst_frame%0d: %0d samples wrong for word %h, expected 0", f, bad, w);
            else passed++;
        end
        total++; if (cap_busy[s + 20*int'(FR1) - 1] !== 1'b1 || cap_busy[s + 20*int'(FR1)] !== 1'b0 ||
                     cap_tx[s + 20*int'(FR1)] !== 1'b1)
            $display("FAIL burst_end: got busy=%b/%b tx=%b expected 1/0 1", cap_busy[s + 20*int'(FR1) - 1],
                     cap_busy[s + 20*int'(FR1)], cap_tx[s + 20*int'(FR1)]);
        else passed++;
    endtask

    task automatic test_simul_full;
        logic [7:0] got;
        int         cyc;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h10 + 8'(i); data_valid = 1'b1;
            @(negedge clk);
        end
        data_valid = 1'b0;
        total++; if (fifo_count !== 5'd3) $display("FAIL simul_pre_count: got %0d expected 3", fifo_count); else passed++;
        repeat (FR1 - 3) @(negedge clk);
        total++; if (fifo_count !== 5'd3 || tx !== 1'b1)
            $display("FAIL simul_before_pop: got cnt=%0d tx=%b expected 3 1", fifo_count, tx);
        else passed++;
        data_in = 8'h14; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        total++; if (fifo_count !== 5'd3) $display("FAIL simul_push_pop: got %0d expected 3", fifo_count); else passed++;
        total++; if (tx !== 1'b0) $display("FAIL simul_gapless_start: got %b expected 0", tx); else passed++;
        for (int i = 5; i < 18; i++) begin
            data_in = 8'h10 + 8'(i); data_valid = 1'b1;
            @(negedge clk);
        end
        data_in = 8'hEE;
        total++; if (fifo_count !== 5'd16 || data_ready !== 1'b0)
            $display("FAIL full_state: got cnt=%0d rdy=%b expected 16 0", fifo_count, data_ready);
        else passed++;
        repeat (3) @(negedge clk);
        data_valid = 1'b0;
        total++; if (fifo_count !== 5'd16) $display("FAIL full_push_ignored: got %0d expected 16", fifo_count); else passed++;
        cyc = 0;
        while (fifo_count == 5'd16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (fifo_count !== 5'd15 || data_ready !== 1'b1 || tx !== 1'b0)
            $display("FAIL full_after_pop: got cnt=%0d rdy=%b tx=%b expected 15 1 0", fifo_count, data_ready, tx);
        else passed++;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            repeat (8) @(negedge clk);
            got[k] = tx;
        end
        total++; if (got !== 8'h12) $display("FAIL full_head_word: got %h expected 12", got); else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++; if (fifo_count !== 5'd0) $display("FAIL full_flush: got %0d expected 0", fifo_count); else passed++;
    endtask

    task automatic test_reset_mid;
        int starts;
        data_in = 8'h33; data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h44;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b1 || fifo_count !== 5'd1)
            $display("FAIL rstmid_pre: got busy=%b cnt=%0d expected 1 1", busy, fifo_count);
        else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++; if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx); else passed++;
        total++; if (fifo_count !== 5'd0 || busy !== 1'b0)
            $display("FAIL rstmid_flush: got cnt=%0d busy=%b expected 0 0", fifo_count, busy);
        else passed++;
        starts = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1) starts++;
            @(negedge clk);
        end
        total++; if (starts != 0) $display("FAIL rstmid_no_resume: %0d low samples, expected 0", starts); else passed++;
    endtask

    task automatic test_dut2;
        logic [10:0] exp;
        int          bad;
`ifdef UART_TX_PARITY_EN
        exp = 11'b11010000010;
`else
        exp = {1'b0, 10'b1110000010};
`endif
        data_in2 = 7'h41; data_valid2 = 1'b1;
        @(negedge clk);
        data_valid2 = 1'b0;
        total++; if (fifo_count2 !== 3'd1) $display("FAIL d2_count: got %0d expected 1", fifo_count2); else passed++;
        @(negedge clk);
        for (int i = 0; i < int'(FR2) + 1; i++) begin
            cap_tx[i] = tx2; cap_busy[i] = busy2;
            @(negedge clk);
        end
        for (int b = 0; b < int'(NB2); b++) begin
            bad = 0;
            for (int j = 0; j < 8; j++) if (cap_tx[b*8 + j] !== exp[b]) bad++;
            total++;
            if (bad != 0) $display("FAIL d2_bit%0d: %0d of 8 samples differ from expected %b", b, bad, exp[b]);
            else passed++;
        end
        total++; if (cap_busy[FR2-1] !== 1'b1 || cap_busy[FR2] !== 1'b0)
            $display("FAIL d2_length: got busy_last=%b busy_after=%b expected 1 0", cap_busy[FR2-1], cap_busy[FR2]);
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_burst();
        test_simul_full();
        test_reset_mid();
        test_dut2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Buffered, parametrised UART transmitter for the camera/HDMI debug path. Accepts words over a valid/ready stream into an internal FIFO and serialises them back-to-back onto `tx` with a built-in baud divider. It has configurable data width, stop bits and optional parity. Upstream logic never needs to watch a busy flag or drop data: it stalls on `data_ready` instead.

## Interface
- `CLOCK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `DATA_BITS`, 8: payload bits per frame, legal range 5–9.
- `STOP_BITS`, 1: stop bits per frame, legal values 1 or 2.
- `FIFO_DEPTH`, 16: buffered words; must be a power of 2 and at least 2.
- `PARITY_ODD`, 0: parity sense, where 0 = even and 1 = odd. Only meaningful with `UART_TX_PARITY_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_in`  in  DATA_BITS  word to send.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  FIFO can accept a word; a transfer occurs on any edge where valid and ready are both high.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  a frame is in flight or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of words held in the FIFO.

## Operation
- Baud divider: `DIV = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE`, a compile-time constant. Elaboration fails if `DIV < 2`.
- Every line bit lasts exactly `DIV` clocks.
- Frame layout, in order:
  - one start bit (0);
  - `DATA_BITS` data bits, LSB first;
  - parity bit, only when enabled;
  - `STOP_BITS` stop bits (1).
- Parity bit = XOR of the data bits, inverted when `PARITY_ODD=1`.
- State machine: IDLE → START → DATA → PARITY → STOP → IDLE or START.
  - PARITY is skipped when the feature is compiled out.
  - At the end of the last stop bit, if the FIFO is non-empty, the FSM pops the next word and goes straight to START, so there is no idle gap between frames.
  - Otherwise it goes to IDLE.
- IDLE holds `tx=1`. When the FIFO is non-empty, IDLE pops the head word into the shift register and enters START.
- The FIFO is written on valid&ready and popped only by the FSM.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - `data_ready = (fifo_count != FIFO_DEPTH)`. This is registered/derived from the count, with no combinational path from `data_valid`.
  - When full, `data_ready` is low and `data_in` is ignored; nothing is overwritten.
- `busy = (state != IDLE) || (fifo_count != 0)`.

## Timing
Reset values and reset behaviour:
- `tx=1`, `data_ready=1`, `busy=0`, `fifo_count=0`, FSM in IDLE, divider and bit counter at 0.
- Reset asserted mid-frame aborts the frame: `tx` is 1 after the next edge and the FIFO is emptied. No partial frame resumes.

Cycle-level behaviour:
- Latency from an empty, idle block:
  - word accepted at edge E0;
  - popped at E1;
  - `tx` falls after E1 (start bit visible one cycle after acceptance);
  - `fifo_count` reads 1 after E0 and 0 after E1.
- Frame length is `DIV × (1 + DATA_BITS + P + STOP_BITS)` clocks, where P = 1 with parity enabled and 0 without.
- Consecutive frames abut exactly: the next start bit begins on the clock after the last stop-bit cycle.
- With the FIFO full during a frame, `data_ready` rises on the clock after the pop edge.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity bit are present, with polarity set by `PARITY_ODD`.
- Not defined: no parity logic, the frame omits the bit, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - function `uart_div(clock_freq, baud_rate)` returning `DIV`;
  - function `uart_parity(data, odd)`.
- Sub-module `uart_sync_fifo`: single-clock FIFO with push/pop/full/empty/count. It is parametrised by width and depth and uses wrap-around pointers with one extra bit.
- Top level holds the divider, bit counter, shift register and FSM.

## Test plan
All scenarios use `CLOCK_FREQ=8×BAUD_RATE` (so `DIV=8`), `DATA_BITS=8`, `STOP_BITS=1` unless stated otherwise.
1. Reset, then one push of 0x55 with parity off → `tx` is 0 one cycle after acceptance, then 1,0,1,0,1,0,1,0, then 1. Each bit lasts 8 clocks (80 clocks total), then `busy=0`.
2. `UART_TX_PARITY_EN`, even parity, push 0x07 → parity bit = 1 and the frame is 88 clocks. With `PARITY_ODD=1` → parity bit = 0.
3. Burst of 20 pushes with `FIFO_DEPTH=16` and `data_valid` held high → `data_ready` drops at count 16. All 20 words are transmitted in order, gap-free (20×80 clocks after the first start bit), and none are lost.
4. Simultaneous push and pop with count=3 → count stays 3. Push while full → ignored, count stays 16.
5. `reset_n` low for one clock mid-data-bit → `tx=1` after the reset edge, `fifo_count=0`, `busy=0`, and no further start bit.
6. `DATA_BITS=7`, `STOP_BITS=2`, push 0x41 → 7 data bits, then two 8-clock stop bits, 80 clocks total.
